packet_rr_scheduler: RTL and testbench

- Round-robin packet scheduler in front of the data-processing dispatcher.
- Shares one downstream AXI-Stream datapath between PORT_COUNT upstream AXI-Stream sources.
- Grants whole packets only, holding each grant from the first beat to tlast.
- A per-port enable mask, driven from the AXI-lite control registers, selects which sources may compete.

---
 rtl/packet_rr_scheduler.sv | 177 +++++++++++++++++
 tb/tb_packet_rr_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_rr_scheduler.sv
// -----------------------------------------------------------------------------
// packet_rr_scheduler
//   Round-robin packet scheduler that shares one downstream AXI-Stream path
//   between PORT_COUNT upstream sources. A grant covers a whole packet, from
//   its first beat through tlast. Only ports whose port_enable bit is set may
//   compete. The mask is sampled only while idle.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   port_enable         per-port arbitration enable (bit i = port i)
//   s_axis_*            packed upstream streams, port i at slice i
//   m_axis_*            shared downstream stream; m_axis_tid = source port
//   grant_valid         high while a packet grant is held
//   grant_port          currently or most recently granted port
//
// Optional build macro PKT_SCHED_STATS_EN adds:
//   stats_clear         synchronous clear; it wins over a same-cycle increment
//   stat_pkt_count      per-port forwarded packet counters, 32 bits each
//   stat_beat_count     total forwarded beats
// -----------------------------------------------------------------------------
module packet_rr_scheduler #(
    parameter int PORT_COUNT      = 4,
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int PORT_WIDTH      = $clog2(PORT_COUNT),
    parameter int STATE_WIDTH     = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [PORT_COUNT-1:0]                 port_enable,
    input  logic [PORT_COUNT*AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORT_COUNT*AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [PORT_COUNT-1:0]                 s_axis_tlast,
    input  logic [PORT_COUNT-1:0]                 s_axis_tvalid,
    output logic [PORT_COUNT-1:0]                 s_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic                                  m_axis_tlast,
    output logic                                  m_axis_tvalid,
    output logic [PORT_WIDTH-1:0]                 m_axis_tid,
    input  logic                                  m_axis_tready,
`ifdef PKT_SCHED_STATS_EN
    input  logic                                  stats_clear,
    output logic [PORT_COUNT*32-1:0]              stat_pkt_count,
    output logic [31:0]                           stat_beat_count,
`endif
    output logic                                  grant_valid,
    output logic [PORT_WIDTH-1:0]                 grant_port
);

    typedef enum logic [STATE_WIDTH-1:0] {
        IDLE    = STATE_WIDTH'(0),
        FORWARD = STATE_WIDTH'(1)
    } state_t;

    state_t                  state_reg, state_next;
    logic [PORT_WIDTH-1:0]   grant_port_reg, grant_port_next;
    logic [PORT_WIDTH-1:0]   last_grant_reg, last_grant_next;

    logic [AXIS_DATA_WIDTH-1:0] tdata_arr [PORT_COUNT];
    logic [AXIS_KEEP_WIDTH-1:0] tkeep_arr [PORT_COUNT];

    logic [PORT_COUNT-1:0]   req;
    logic                    arb_found;
    logic [PORT_WIDTH-1:0]   arb_winner;
    logic [PORT_WIDTH-1:0]   arb_idx;
    logic                    xfer;
    logic                    fwd;

    assign fwd  = (state_reg == FORWARD);
    assign xfer = m_axis_tvalid && m_axis_tready;
    assign req  = s_axis_tvalid & port_enable;

    // Unpack the per-port slices; only the granted port sees downstream ready.
    for (genvar gi = 0; gi < PORT_COUNT; gi++) begin : g_port
        assign tdata_arr[gi]     = s_axis_tdata[gi*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
        assign tkeep_arr[gi]     = s_axis_tkeep[gi*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
        assign s_axis_tready[gi] = fwd && (grant_port_reg == PORT_WIDTH'(gi)) && m_axis_tready;
    end

    // Rotating priority: the search starts one past the last granted port, so
    // the port that just finished has the lowest priority.
    always_comb begin
        arb_found  = 1'b0;
        arb_winner = '0;
        arb_idx    = '0;
        for (int k = 1; k <= PORT_COUNT; k++) begin
            arb_idx = PORT_WIDTH'((int'(last_grant_reg) + k) % PORT_COUNT);
            if (!arb_found && req[arb_idx]) begin
                arb_found  = 1'b1;
                arb_winner = arb_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            grant_port_reg <= '0;
            last_grant_reg <= PORT_WIDTH'(PORT_COUNT - 1);
        end else begin
            state_reg      <= state_next;
            grant_port_reg <= grant_port_next;
            last_grant_reg <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_port_next = grant_port_reg;
        last_grant_next = last_grant_reg;
        // The data, keep and id paths follow grant_port even when idle, because
        // the downstream side ignores them there. This avoids a mux on valid.
        m_axis_tdata    = tdata_arr[grant_port_reg];
        m_axis_tkeep    = tkeep_arr[grant_port_reg];
        m_axis_tid      = grant_port_reg;
        m_axis_tvalid   = 1'b0;
        m_axis_tlast    = 1'b0;
        grant_valid     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (arb_found) begin
                    grant_port_next = arb_winner;
                    state_next      = FORWARD;
                end
            end
            FORWARD: begin
                m_axis_tvalid = s_axis_tvalid[grant_port_reg];
                m_axis_tlast  = s_axis_tlast[grant_port_reg];
                grant_valid   = 1'b1;
                // The grant is held across valid gaps. It is released only
                // when the tlast beat is accepted.
                if (xfer && m_axis_tlast) begin
                    last_grant_next = grant_port_reg;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign grant_port = grant_port_reg;

`ifdef PKT_SCHED_STATS_EN
    logic [31:0] beat_count_reg;

    for (genvar gi = 0; gi < PORT_COUNT; gi++) begin : g_stat
        logic [31:0] pkt_count_reg;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pkt_count_reg <= '0;
            end else if (stats_clear) begin
                pkt_count_reg <= '0;
            end else if (xfer && m_axis_tlast && (grant_port_reg == PORT_WIDTH'(gi))) begin
                pkt_count_reg <= pkt_count_reg + 32'd1;
            end
        end
        assign stat_pkt_count[gi*32 +: 32] = pkt_count_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count_reg <= '0;
        end else if (stats_clear) begin
            beat_count_reg <= '0;
        end else if (xfer) begin
            beat_count_reg <= beat_count_reg + 32'd1;
        end
    end

    assign stat_beat_count = beat_count_reg;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_packet_rr_scheduler.sv
module tb_packet_rr_scheduler;
    localparam int P  = 4;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int PW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [P-1:0]    port_enable;
    logic [P*DW-1:0] s_tdata;
    logic [P*KW-1:0] s_tkeep;
    logic [P-1:0]    s_tlast, s_tvalid, s_tready;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tlast, m_tvalid, m_tready;
    logic [PW-1:0]   m_tid;
    logic            grant_valid;
    logic [PW-1:0]   grant_port;
    logic            stats_clear;
`ifdef PKT_SCHED_STATS_EN
    logic [P*32-1:0] stat_pkt_count;
    logic [31:0]     stat_beat_count;
`endif

    always #5 clk = ~clk;

    packet_rr_scheduler #(.PORT_COUNT(P), .AXIS_DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .port_enable(port_enable),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tid(m_tid), .m_axis_tready(m_tready),
`ifdef PKT_SCHED_STATS_EN
        .stats_clear(stats_clear), .stat_pkt_count(stat_pkt_count),
        .stat_beat_count(stat_beat_count),
`endif
        .grant_valid(grant_valid), .grant_port(grant_port)
    );

    // Source packet queues and the reference model state.
    beat_t       src_q [P][$];
    int          hold [P];
    int          gap_pct, rdy_mode;
    logic        rdy_phase;
    int          n_cmp, n_err;
    bit          mdl_busy;
    int          mdl_port, mdl_last, mdl_gport;
    int          tid_log[$];
    bit          last_log[$];
    int          exp_log[$];
    int unsigned exp_pkt [P];
    int unsigned exp_beats;
    bit          clear_on_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mdl_busy  = 1'b0;
        mdl_port  = 0;
        mdl_gport = 0;
        mdl_last  = P - 1;
        exp_beats = 0;
        for (int i = 0; i < P; i++) exp_pkt[i] = 0;
    endtask

    task automatic push_pkt(input int port, input int len);
        beat_t b;
        for (int n = 0; n < len; n++) begin
            b.data = {$urandom, $urandom};
            b.keep = KW'($urandom);
            b.last = (n == len - 1);
            src_q[port].push_back(b);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < P; i++)
            if (((port_enable >> i) & P'(1)) != '0) s += src_q[i].size();
        return s;
    endfunction

    task automatic apply_inputs();
        for (int i = 0; i < P; i++) begin
            if (src_q[i].size() > 0) begin
                s_tdata[i*DW +: DW] = src_q[i][0].data;
                s_tkeep[i*KW +: KW] = src_q[i][0].keep;
                s_tlast[i]          = src_q[i][0].last;
                s_tvalid[i]         = (hold[i] == 0) && (int'($urandom_range(99)) >= gap_pct);
            end else begin
                s_tdata[i*DW +: DW] = {$urandom, $urandom};
                s_tkeep[i*KW +: KW] = KW'($urandom);
                s_tlast[i]          = 1'($urandom);
                s_tvalid[i]         = 1'b0;
            end
        end
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1: begin rdy_phase = ~rdy_phase; m_tready = rdy_phase; end
            default: m_tready = 1'($urandom_range(1));
        endcase
    endtask

    // One clock: check outputs at the falling edge against the model, then
    // advance the model and sources after the rising edge.
    task automatic step();
        int           g, win, idx;
        logic [P-1:0] req, exp_rdy;
        bit           xfer, vg, cleared;
        beat_t        b;
        win  = -1;
        xfer = 1'b0;
        g    = mdl_port;
        @(negedge clk);
        if (!mdl_busy) begin
            chk("idle_grant_valid", 64'(grant_valid), 64'(0));
            chk("idle_m_tvalid", 64'(m_tvalid), 64'(0));
            chk("idle_s_tready", 64'(s_tready), 64'(0));
            chk("idle_grant_port", 64'(grant_port), 64'(mdl_gport));
            req = s_tvalid & port_enable;
            for (int k = 1; k <= P; k++) begin
                idx = (mdl_last + k) % P;
                if (win < 0 && (((req >> idx) & P'(1)) != '0)) win = idx;
            end
        end else begin
            vg      = ((s_tvalid >> g) & P'(1)) != '0;
            exp_rdy = m_tready ? (P'(1) << g) : P'(0);
            chk("fwd_grant_valid", 64'(grant_valid), 64'(1));
            chk("fwd_tid", 64'(m_tid), 64'(g));
            chk("fwd_grant_port", 64'(grant_port), 64'(g));
            chk("fwd_m_tvalid", 64'(m_tvalid), 64'(vg));
            chk("fwd_s_tready", 64'(s_tready), 64'(exp_rdy));
            if (vg) begin
                chk("fwd_tdata", m_tdata, src_q[g][0].data);
                chk("fwd_tkeep", 64'(m_tkeep), 64'(src_q[g][0].keep));
                chk("fwd_tlast", 64'(m_tlast), 64'(src_q[g][0].last));
            end
            xfer = vg && m_tready;
        end
        if (clear_on_last && xfer && src_q[g][0].last) stats_clear = 1'b1;
        cleared = stats_clear;
        @(posedge clk);
        #1;
        stats_clear = 1'b0;
        if (!mdl_busy) begin
            if (win >= 0) begin
                mdl_busy  = 1'b1;
                mdl_port  = win;
                mdl_gport = win;
            end
        end else if (xfer) begin
            b = src_q[g].pop_front();
            tid_log.push_back(g);
            last_log.push_back(b.last);
            if (!cleared) begin
                exp_beats++;
                if (b.last) exp_pkt[g]++;
            end
            if (b.last) begin
                mdl_busy = 1'b0;
                mdl_last = g;
            end
        end
        if (cleared) begin
            exp_beats = 0;
            for (int i = 0; i < P; i++) exp_pkt[i] = 0;
        end
        for (int i = 0; i < P; i++) if (hold[i] > 0) hold[i]--;
        apply_inputs();
    endtask

    task automatic run_drain(input int budget, output int cycles);
        cycles = 0;
        while ((pending() != 0 || mdl_busy) && cycles < budget) begin
            step();
            cycles++;
        end
        chk("drain_pending", 64'(pending()), 64'(0));
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_len"}, 64'(tid_log.size()), 64'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < tid_log.size(); i++)
            chk(tag, 64'(tid_log[i]), 64'(exp_log[i]));
        tid_log.delete();
        last_log.delete();
    endtask

`ifdef PKT_SCHED_STATS_EN
    task automatic check_stats(input string tag);
        for (int i = 0; i < P; i++)
            chk({tag, "_pkt"}, 64'(stat_pkt_count[i*32 +: 32]), 64'(exp_pkt[i]));
        chk({tag, "_beat"}, 64'(stat_beat_count), 64'(exp_beats));
    endtask
`endif

    initial begin
        int cyc;
        n_cmp = 0; n_err = 0;
        port_enable = '1; s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tkeep = '0;
        m_tready = 1'b1; stats_clear = 1'b0; clear_on_last = 1'b0;
        gap_pct = 0; rdy_mode = 0; rdy_phase = 1'b0;
        for (int i = 0; i < P; i++) hold[i] = 0;
        model_reset();

        // Check the reset state.
        repeat (2) @(posedge clk);
        #1;
        s_tvalid = '1;
        #1;
        chk("rst_grant_valid", 64'(grant_valid), 64'(0));
        chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst_m_tlast", 64'(m_tlast), 64'(0));
        chk("rst_s_tready", 64'(s_tready), 64'(0));
        chk("rst_grant_port", 64'(grant_port), 64'(0));
`ifdef PKT_SCHED_STATS_EN
        check_stats("rst_stats");
`endif
        rst_n = 1'b1;
        apply_inputs();

        // Test 1: single-beat packets on all ports. Grants rotate from port 0.
        for (int i = 0; i < P; i++) push_pkt(i, 1);
        push_pkt(0, 1);
        apply_inputs();
        run_drain(100, cyc);
        chk("t1_cycles", 64'(cyc), 64'(10));
        exp_log = '{0, 1, 2, 3, 0};
        check_log("t1_order");

        // Test 2: port 0 starts requesting in the middle of port 2's packet.
        push_pkt(2, 5);
        hold[0] = 3;
        push_pkt(0, 1);
        apply_inputs();
        run_drain(100, cyc);
        exp_log = '{2, 2, 2, 2, 2, 0};
        check_log("t2_order");

        // Test 3: enable mask 1010 leaves only ports 1 and 3.
        port_enable = 4'b1010;
        push_pkt(0, 1); push_pkt(2, 1);
        push_pkt(1, 1); push_pkt(1, 1); push_pkt(3, 1); push_pkt(3, 1);
        apply_inputs();
        run_drain(100, cyc);
        exp_log = '{1, 3, 1, 3};
        check_log("t3_order");
        src_q[0].delete(); src_q[2].delete();
        port_enable = '1;
        apply_inputs();

        // Test 4: downstream ready toggles during a 4-beat packet.
        rdy_mode = 1; rdy_phase = 1'b0;
        push_pkt(1, 4);
        apply_inputs();
        run_drain(100, cyc);
        chk("t4_last_pos", 64'({last_log[0], last_log[1], last_log[2], last_log[3]}), 64'(4'b0001));
        exp_log = '{1, 1, 1, 1};
        check_log("t4_order");
        rdy_mode = 0;

        // Test 5: reset in the middle of a packet.
        push_pkt(2, 6);
        apply_inputs();
        cyc = 0;
        while (tid_log.size() < 2 && cyc < 40) begin step(); cyc++; end
        chk("t5_pre_beats", 64'(tid_log.size()), 64'(2));
        #2 rst_n = 1'b0;
        #1;
        chk("t5_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("t5_s_tready", 64'(s_tready), 64'(0));
        chk("t5_grant_valid", 64'(grant_valid), 64'(0));
        chk("t5_m_tlast", 64'(m_tlast), 64'(0));
        chk("t5_grant_port", 64'(grant_port), 64'(0));
        src_q[2].delete();
        tid_log.delete(); last_log.delete();
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        push_pkt(2, 1); push_pkt(0, 1);
        apply_inputs();
        run_drain(100, cyc);
        exp_log = '{0, 2};
        check_log("t5_order");

`ifdef PKT_SCHED_STATS_EN
        // Test 6: statistics counters and the clear-priority rule.
        stats_clear = 1'b1;
        step();
        push_pkt(1, 2); push_pkt(1, 3); push_pkt(1, 1);
        apply_inputs();
        run_drain(100, cyc);
        chk("t6_pkt1", 64'(stat_pkt_count[32 +: 32]), 64'(3));
        chk("t6_beats", 64'(stat_beat_count), 64'(6));
        check_stats("t6_model");
        clear_on_last = 1'b1;
        push_pkt(1, 1);
        apply_inputs();
        run_drain(100, cyc);
        clear_on_last = 1'b0;
        chk("t6_clr_pkt1", 64'(stat_pkt_count[32 +: 32]), 64'(0));
        chk("t6_clr_beats", 64'(stat_beat_count), 64'(0));
        tid_log.delete(); last_log.delete();
`endif

        // Test 7: random traffic, gaps, backpressure and mask changes.
        gap_pct = 25; rdy_mode = 2;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(15) == 0) port_enable = P'($urandom_range(15));
            for (int i = 0; i < P; i++)
                if (src_q[i].size() < 6 && $urandom_range(7) == 0)
                    push_pkt(i, int'($urandom_range(4, 1)));
            step();
        end
        port_enable = '1; gap_pct = 0; rdy_mode = 0;
        apply_inputs();
        run_drain(1000, cyc);
        tid_log.delete(); last_log.delete();
`ifdef PKT_SCHED_STATS_EN
        check_stats("t7_stats");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
